// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparators: FSM states,
// result encodings and the chunk-count / cycle-counter width derivation.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result vector ordering is {greater, equal, less}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b100;

    function automatic int calc_nchunk(input int width, input int digit);
        return width / digit;
    endfunction

    // Wide enough to hold the full chunk count itself, not just NCHUNK-1
    function automatic int calc_cw(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage

// File: rtl/seq_mag_compare_cmp_digit.sv
// Combinational unsigned compare of one DIGIT-wide slice of each operand.
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             gt,
    output logic             eq
);

    assign gt = (a_dig > b_dig);
    assign eq = (a_dig == b_dig);

endmodule

// File: rtl/seq_mag_compare.sv
// Multi-cycle magnitude comparator, MSB digit first with early exit on the first
// differing digit. Define SEQ_MAG_COMPARE_SIGNED_EN to add two's complement mode.
module seq_mag_compare
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter int CW    = seq_cmp_pkg::calc_cw(WIDTH, DIGIT)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SEQ_MAG_COMPARE_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             greater,
    output logic             equal,
    output logic             less,
    output logic [CW-1:0]    cmp_cycles
);

    localparam int NCHUNK = calc_nchunk(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
            $error("seq_mag_compare: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [CW-1:0]    cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [2:0]       result_r;
    logic [CW-1:0]    cycles_r;

    logic [WIDTH-1:0] a_load_s;
    logic [WIDTH-1:0] b_load_s;
    logic             dig_gt_s;
    logic             dig_eq_s;
    logic             last_s;
    logic [2:0]       res_s;

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_cmp_digit (
        .a_dig (a_sh_r[WIDTH-1 -: DIGIT]),
        .b_dig (b_sh_r[WIDTH-1 -: DIGIT]),
        .gt    (dig_gt_s),
        .eq    (dig_eq_s)
    );

`ifdef SEQ_MAG_COMPARE_SIGNED_EN
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1'b1) << (WIDTH - 1);

    // Operand conditioning: flipping both sign bits maps two's complement onto unsigned order
    always_comb begin
        a_load_s = a;
        b_load_s = b;
        if (signed_mode) begin
            a_load_s = a ^ MSB_MASK;
            b_load_s = b ^ MSB_MASK;
        end else begin
            a_load_s = a;
            b_load_s = b;
        end
    end
`else
    // Operand conditioning: unsigned only, operands load unchanged
    always_comb begin
        a_load_s = a;
        b_load_s = b;
    end
`endif

    // Per-digit decision for the current SCAN cycle
    always_comb begin
        res_s  = RES_NONE;
        last_s = (cnt_r == LAST_CNT);
        if (!dig_eq_s) begin
            res_s = dig_gt_s ? RES_GT : RES_LT;
        end else begin
            res_s = RES_EQ;
        end
    end

    // Control FSM, shift datapath and registered handshake/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= RES_NONE;
            cycles_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    if (in_valid && in_ready_r) begin
                        a_sh_r     <= a_load_s;
                        b_sh_r     <= b_load_s;
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= SCAN;
                    end
                end
                SCAN: begin
                    if (!dig_eq_s || last_s) begin
                        result_r <= res_s;
                        cycles_r <= cnt_r + CW'(1);
                        state_r  <= DONE;
                    end else begin
                        a_sh_r <= a_sh_r << DIGIT;
                        b_sh_r <= b_sh_r << DIGIT;
                        cnt_r  <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle only publishes; the handshake starts once valid is up
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready                 = in_ready_r;
    assign out_valid                = out_valid_r;
    assign {greater, equal, less}   = result_r;
    assign cmp_cycles               = cycles_r;

endmodule
